ctrl_decode_pipe: RTL and testbench
===================================

Name: ctrl_decode_pipe

Overview:
- Pipelined successor to the single-cycle main control decoder.
- Decodes the 32-bit instruction in ID and registers the full control bundle plus register addresses into the ID/EX stage.
- Detects load-use hazards internally, supports external stall and flush, and counts inserted bubbles.
- Sits between the IF/ID register and the EX stage of the 5-stage MIPS datapath.

Parameters:
ALUOP_W, 3, width of ALU_op_o; codes 0..4 and 7 must fit in it (minimum 3).
REG_AW, 5, register-address width for rs/rt/rd and the jal link register (all ones).
HAZARD_EN, 1, 1 = internal load-use detection enabled; 0 = hazard_stall_o tied to 0.
CNT_W, 16, width of the saturating bubble counter.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
instr_i  in  32  instruction from IF/ID
instr_valid_i  in  1  instr_i holds a real instruction
stall_i  in  1  hold the ID/EX register (downstream back-pressure)
flush_i  in  1  load a bubble (taken branch/jump)
hazard_stall_o  out  1  combinational; freeze PC and IF/ID this cycle
ex_valid_o  out  1  ID/EX holds a real instruction
RegWrite_o  out  1  registered control
ALU_op_o  out  ALUOP_W  0 lw/sw, 1 branch, 2 R-type, 3 addi, 4 slti, 7 other
ALUSrc_o  out  1  1 = immediate operand
RegDst_o  out  2  0 rt, 1 rd, 2 link register (jal)
Branch_o  out  1  conditional branch
BranchType_o  out  2  0 beq, 1 bne, 2 bge, 3 bgt
Jump_o  out  1  j, jal or jr
JumpReg_o  out  1  jr (op 0, funct 6'h08)
MemRead_o  out  1  lw
MemWrite_o  out  1  sw
MemtoReg_o  out  2  0 ALU, 1 memory, 2 PC+4
rs_o, rt_o, rd_o  out  REG_AW each  registered instr fields [25:21], [20:16], [15:11]
illegal_o  out  1  registered; unknown opcode was decoded
bubble_cnt_o  out  CNT_W  saturating count of bubbles inserted

Behaviour:
- Opcode map: R=0, bge=1, j=2, jal=3, beq=4, bne=5, bgt=7, addi=8, slti=10, lw=35, sw=43.
  - Any other opcode is illegal: all controls 0, ALU_op 7, illegal_o=1.
- Decode (combinational, then registered):
  - RegWrite = R-type excluding jr, or addi/slti/lw/jal.
  - ALUSrc = addi/slti/lw/sw.
  - Branch = beq/bne/bge/bgt.
  - Jump = j/jal/jr.
- Bubble = every output 0 except ALU_op_o=7; ex_valid_o=0.
- hazard_stall_o = HAZARD_EN & ex_valid_o & MemRead_o & rt_o!=0 & instr_valid_i & match, where match is:
  - rt_o==instr rs for any opcode that reads rs (all except j/jal), or
  - rt_o==instr rt for R-type, beq/bne/bge/bgt, or sw.
- ID/EX update priority at each rising edge, highest first:
  1. rst_i: bubble, illegal_o=0, bubble_cnt_o=0.
  2. flush_i: bubble, counter increments.
  3. stall_i: hold all registers; counter unchanged; hazard_stall_o still evaluated.
  4. hazard_stall_o: bubble, counter increments.
  5. otherwise load the decoded instruction.
     - If instr_valid_i=0, load a bubble; the counter does not increment.
- illegal_o updates only on a load step (5); bubbles from steps 1, 2, 4 or an invalid instruction clear it.
- Counter saturates at all ones, with no wrap.
- Latency: one cycle from instr_i to the registered outputs.
- Reset mid-stall or mid-hazard: the outputs are bubbles on the next edge.
- Simultaneous flush_i and stall_i: flush wins.

Test Plan:
1. Reset: rst_i=1 for 2 cycles -> all outputs 0 except ALU_op_o=7; bubble_cnt_o=0.
2. Decode sweep: lw $8,0($9) (0x8D280000) -> next cycle MemRead=1, RegWrite=1, ALUSrc=1, MemtoReg=1, RegDst=0, ALU_op=0, rt_o=8.
   - jal (op 3) -> RegDst=2, MemtoReg=2, Jump=1.
   - jr (0x01200008) -> Jump=1, JumpReg=1, RegWrite=0.
   - bgt -> Branch=1, BranchType=3.
3. Load-use: lw $8 then add $10,$8,$11 -> hazard_stall_o=1 in the add's ID cycle; ID/EX becomes a bubble; bubble_cnt_o=1; the next cycle decodes the add normally.
   - Repeat with lw $0 -> no stall.
4. Flush plus stall priority: flush_i=1 and stall_i=1 together -> bubble loaded.
   - stall_i alone for 3 cycles -> outputs held unchanged, counter unchanged.
5. Illegal opcode 6'h3F -> illegal_o=1 for one cycle; ALU_op_o=7; RegWrite=0; MemWrite=0.
6. Saturation: CNT_W=2 with 5 flushes -> bubble_cnt_o stops at 3.

Source files
------------

// File: rtl/ctrl_decode_pipe.sv
// ID-stage control decoder with registered ID/EX control bundle, internal
// load-use hazard detection, external stall/flush and a saturating bubble counter.
module ctrl_decode_pipe #(
    parameter int ALUOP_W   = 3,
    parameter int REG_AW    = 5,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        instr_i,
    input  logic               instr_valid_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic               hazard_stall_o,
    output logic               ex_valid_o,
    output logic               RegWrite_o,
    output logic [ALUOP_W-1:0] ALU_op_o,
    output logic               ALUSrc_o,
    output logic [1:0]         RegDst_o,
    output logic               Branch_o,
    output logic [1:0]         BranchType_o,
    output logic               Jump_o,
    output logic               JumpReg_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic [1:0]         MemtoReg_o,
    output logic [REG_AW-1:0]  rs_o,
    output logic [REG_AW-1:0]  rt_o,
    output logic [REG_AW-1:0]  rd_o,
    output logic               illegal_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_BGE  = 6'd1;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_BGT  = 6'd7;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_SLTI = 6'd10;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] FN_JR   = 6'h08;

    typedef struct packed {
        logic               reg_write;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic [1:0]         reg_dst;
        logic               branch;
        logic [1:0]         branch_type;
        logic               jump;
        logic               jump_reg;
        logic               mem_read;
        logic               mem_write;
        logic [1:0]         mem_to_reg;
        logic               illegal;
    } ctrl_t;

    ctrl_t              w_dec;
    ctrl_t              w_bubble;
    ctrl_t              r_ctrl;
    logic               r_ex_valid;
    logic [REG_AW-1:0]  r_rs;
    logic [REG_AW-1:0]  r_rt;
    logic [REG_AW-1:0]  r_rd;
    logic [CNT_W-1:0]   r_cnt;

    logic [5:0]         w_op;
    logic               w_is_jr;
    logic               w_reads_rs;
    logic               w_reads_rt;
    logic               w_hazard;
    logic               w_take_bubble;
    logic               w_count;
    logic               w_unused_shamt;

    assign w_op           = instr_i[31:26];
    assign w_is_jr        = (w_op == OP_R) && (instr_i[5:0] == FN_JR);
    assign w_unused_shamt = ^instr_i[10:6];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_bubble        = '0;
        w_bubble.alu_op = ALUOP_W'(7);
        w_dec           = w_bubble;
        case (w_op)
            OP_R: begin
                w_dec.reg_write = !w_is_jr;
                w_dec.alu_op    = ALUOP_W'(2);
                w_dec.reg_dst   = 2'd1;
                w_dec.jump      = w_is_jr;
                w_dec.jump_reg  = w_is_jr;
            end
            OP_BGE:  begin w_dec.branch = 1'b1; w_dec.branch_type = 2'd2; w_dec.alu_op = ALUOP_W'(1); end
            OP_BEQ:  begin w_dec.branch = 1'b1; w_dec.branch_type = 2'd0; w_dec.alu_op = ALUOP_W'(1); end
            OP_BNE:  begin w_dec.branch = 1'b1; w_dec.branch_type = 2'd1; w_dec.alu_op = ALUOP_W'(1); end
            OP_BGT:  begin w_dec.branch = 1'b1; w_dec.branch_type = 2'd3; w_dec.alu_op = ALUOP_W'(1); end
            OP_J:    w_dec.jump = 1'b1;
            OP_JAL: begin
                w_dec.jump       = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.reg_dst    = 2'd2;
                w_dec.mem_to_reg = 2'd2;
            end
            OP_ADDI: begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu_op = ALUOP_W'(3); end
            OP_SLTI: begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu_op = ALUOP_W'(4); end
            OP_LW: begin
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.alu_op     = ALUOP_W'(0);
                w_dec.mem_read   = 1'b1;
                w_dec.mem_to_reg = 2'd1;
            end
            OP_SW:   begin w_dec.alu_src = 1'b1; w_dec.mem_write = 1'b1; w_dec.alu_op = ALUOP_W'(0); end
            default: w_dec.illegal = 1'b1;
        endcase
    end

    // Load-use: the load in EX writes a register the instruction in ID reads.
    assign w_reads_rs = (w_op != OP_J) && (w_op != OP_JAL);
    assign w_reads_rt = (w_op == OP_R) || (w_op == OP_BEQ) || (w_op == OP_BNE) ||
                        (w_op == OP_BGE) || (w_op == OP_BGT) || (w_op == OP_SW);
    assign w_hazard   = (HAZARD_EN != 0) && r_ex_valid && r_ctrl.mem_read &&
                        (r_rt != '0) && instr_valid_i &&
                        ((w_reads_rs && (r_rt == REG_AW'(instr_i[25:21]))) ||
                         (w_reads_rt && (r_rt == REG_AW'(instr_i[20:16]))));

    assign w_take_bubble = flush_i || (!stall_i && (w_hazard || !instr_valid_i));
    assign w_count       = flush_i || (!stall_i && w_hazard);

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl     <= w_bubble;
            r_ex_valid <= 1'b0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_take_bubble) begin
                r_ctrl     <= w_bubble;
                r_ex_valid <= 1'b0;
                r_rs       <= '0;
                r_rt       <= '0;
                r_rd       <= '0;
            end else if (!stall_i) begin
                r_ctrl     <= w_dec;
                r_ex_valid <= 1'b1;
                r_rs       <= REG_AW'(instr_i[25:21]);
                r_rt       <= REG_AW'(instr_i[20:16]);
                r_rd       <= REG_AW'(instr_i[15:11]);
            end
            if (w_count && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign hazard_stall_o = w_hazard;
    assign ex_valid_o     = r_ex_valid;
    assign RegWrite_o     = r_ctrl.reg_write;
    assign ALU_op_o       = r_ctrl.alu_op;
    assign ALUSrc_o       = r_ctrl.alu_src;
    assign RegDst_o       = r_ctrl.reg_dst;
    assign Branch_o       = r_ctrl.branch;
    assign BranchType_o   = r_ctrl.branch_type;
    assign Jump_o         = r_ctrl.jump;
    assign JumpReg_o      = r_ctrl.jump_reg;
    assign MemRead_o      = r_ctrl.mem_read;
    assign MemWrite_o     = r_ctrl.mem_write;
    assign MemtoReg_o     = r_ctrl.mem_to_reg;
    assign illegal_o      = r_ctrl.illegal;
    assign rs_o           = r_rs;
    assign rt_o           = r_rt;
    assign rd_o           = r_rd;
    assign bubble_cnt_o   = r_cnt;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: decode sweep, load-use hazards,
// flush/stall priority, illegal opcodes and counter saturation (CNT_W=2 copy).
module tb_ctrl_decode_pipe;

    localparam logic [31:0] I_LW8   = 32'h8D28_0000; // lw   $8,0($9)
    localparam logic [31:0] I_ADD   = 32'h010B_5020; // add  $10,$8,$11
    localparam logic [31:0] I_LW0   = 32'h8D20_0000; // lw   $0,0($9)
    localparam logic [31:0] I_ADD0  = 32'h0000_5020; // add  $10,$0,$0
    localparam logic [31:0] I_J     = 32'h0900_0000; // j with rs field = 8
    localparam logic [31:0] I_SW    = 32'hAD28_0004; // sw   $8,4($9)
    localparam logic [31:0] I_ADDI8 = 32'h2048_0001; // addi $8,$2,1
    localparam logic [31:0] I_JAL   = 32'h0C00_0010;
    localparam logic [31:0] I_JR    = 32'h0120_0008; // jr   $9
    localparam logic [31:0] I_BGT   = 32'h1C22_0004; // bgt  $1,$2
    localparam logic [31:0] I_ILL   = 32'hFC00_0000; // opcode 6'h3F

    logic        clk_i = 1'b0;
    logic        rst_i, instr_valid_i, stall_i, flush_i;
    logic [31:0] instr_i;
    logic        hazard_stall_o, ex_valid_o, RegWrite_o, ALUSrc_o, Branch_o;
    logic        Jump_o, JumpReg_o, MemRead_o, MemWrite_o, illegal_o;
    logic [2:0]  ALU_op_o;
    logic [1:0]  RegDst_o, BranchType_o, MemtoReg_o;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic [15:0] bubble_cnt_o;

    logic        s_rst, s_flush;
    logic        s_hz, s_v, s_rw, s_src, s_br, s_j, s_jr, s_mr, s_mw, s_ill;
    logic [2:0]  s_aluop;
    logic [1:0]  s_dst, s_bt, s_m2r;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [1:0]  s_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ctrl_decode_pipe u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .stall_i(stall_i), .flush_i(flush_i), .hazard_stall_o(hazard_stall_o),
        .ex_valid_o(ex_valid_o), .RegWrite_o(RegWrite_o), .ALU_op_o(ALU_op_o),
        .ALUSrc_o(ALUSrc_o), .RegDst_o(RegDst_o), .Branch_o(Branch_o),
        .BranchType_o(BranchType_o), .Jump_o(Jump_o), .JumpReg_o(JumpReg_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o),
        .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .illegal_o(illegal_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    ctrl_decode_pipe #(.CNT_W(2)) u_sat (
        .clk_i(clk_i), .rst_i(s_rst), .instr_i(32'h0), .instr_valid_i(1'b0),
        .stall_i(1'b0), .flush_i(s_flush), .hazard_stall_o(s_hz),
        .ex_valid_o(s_v), .RegWrite_o(s_rw), .ALU_op_o(s_aluop),
        .ALUSrc_o(s_src), .RegDst_o(s_dst), .Branch_o(s_br),
        .BranchType_o(s_bt), .Jump_o(s_j), .JumpReg_o(s_jr),
        .MemRead_o(s_mr), .MemWrite_o(s_mw), .MemtoReg_o(s_m2r),
        .rs_o(s_rs), .rt_o(s_rt), .rd_o(s_rd), .illegal_o(s_ill),
        .bubble_cnt_o(s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected bundle order: valid, RegWrite, ALU_op, ALUSrc, RegDst, Branch,
    // BranchType, Jump, JumpReg, MemRead, MemWrite, MemtoReg, illegal.
    task automatic check_ctrl(input string tag, input logic v, input logic rw,
                              input logic [2:0] aop, input logic src, input logic [1:0] dst,
                              input logic br, input logic [1:0] bt, input logic j,
                              input logic jr, input logic mr, input logic mw,
                              input logic [1:0] m2r, input logic ill);
        check(tag,
              32'({ex_valid_o, RegWrite_o, ALU_op_o, ALUSrc_o, RegDst_o, Branch_o,
                   BranchType_o, Jump_o, JumpReg_o, MemRead_o, MemWrite_o, MemtoReg_o, illegal_o}),
              32'({v, rw, aop, src, dst, br, bt, j, jr, mr, mw, m2r, ill}));
    endtask

    task automatic check_bubble(input string tag, input int cnt);
        check_ctrl(tag, 0, 0, 3'd7, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        check({tag, "_regs"}, 32'({rs_o, rt_o, rd_o}), 32'h0);
        check({tag, "_cnt"}, 32'(bubble_cnt_o), 32'(cnt));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins);
        instr_i       = ins;
        instr_valid_i = 1'b1;
        #1;
    endtask

    initial begin
        rst_i = 1'b1; s_rst = 1'b1; s_flush = 1'b0;
        instr_i = 32'h0; instr_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0; s_rst = 1'b0;
        check_bubble("reset", 0);

        drive(I_LW8); tick();
        check_ctrl("lw", 1, 1, 3'd0, 1, 2'd0, 0, 2'd0, 0, 0, 1, 0, 2'd1, 0);
        check("lw_rt", 32'(rt_o), 32'd8);
        check("lw_rs", 32'(rs_o), 32'd9);

        drive(I_ADD);
        check("hz_add_rs", 32'(hazard_stall_o), 32'd1);
        tick();
        check_bubble("hz_bubble", 1);
        check("hz_clear", 32'(hazard_stall_o), 32'd0);
        tick();
        check_ctrl("add", 1, 1, 3'd2, 0, 2'd1, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        check("add_regs", 32'({rs_o, rt_o, rd_o}), 32'({5'd8, 5'd11, 5'd10}));

        drive(I_LW0); tick();
        drive(I_ADD0);
        check("hz_lw0", 32'(hazard_stall_o), 32'd0);
        tick();
        check_ctrl("add0", 1, 1, 3'd2, 0, 2'd1, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        check("add0_cnt", 32'(bubble_cnt_o), 32'd1);

        drive(I_LW8); tick();
        drive(I_J);
        check("hz_j", 32'(hazard_stall_o), 32'd0);
        tick();
        check_ctrl("j", 1, 0, 3'd7, 0, 2'd0, 0, 2'd0, 1, 0, 0, 0, 2'd0, 0);

        drive(I_LW8); tick();
        drive(I_SW);
        check("hz_sw_rt", 32'(hazard_stall_o), 32'd1);
        tick();
        check_bubble("sw_bubble", 2);
        tick();
        check_ctrl("sw", 1, 0, 3'd0, 1, 2'd0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 0);

        drive(I_LW8); tick();
        drive(I_ADDI8);
        check("hz_addi_rt", 32'(hazard_stall_o), 32'd0);
        tick();
        check_ctrl("addi", 1, 1, 3'd3, 1, 2'd0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);

        drive(I_JAL); tick();
        check_ctrl("jal", 1, 1, 3'd7, 0, 2'd2, 0, 2'd0, 1, 0, 0, 0, 2'd2, 0);
        drive(I_JR); tick();
        check_ctrl("jr", 1, 0, 3'd2, 0, 2'd1, 0, 2'd0, 1, 1, 0, 0, 2'd0, 0);
        drive(I_BGT); tick();
        check_ctrl("bgt", 1, 0, 3'd1, 0, 2'd0, 1, 2'd3, 0, 0, 0, 0, 2'd0, 0);
        drive(I_ILL); tick();
        check_ctrl("illegal", 1, 0, 3'd7, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 1);
        drive(I_ADDI8); tick();
        check("illegal_clear", 32'(illegal_o), 32'd0);

        flush_i = 1'b1; stall_i = 1'b1; drive(I_ADD); tick();
        flush_i = 1'b0; stall_i = 1'b0;
        check_bubble("flush_stall", 3);

        drive(I_LW8); tick();
        stall_i = 1'b1; drive(I_ADD);
        for (int i = 0; i < 3; i++) begin
            check("stall_hz", 32'(hazard_stall_o), 32'd1);
            tick();
            check_ctrl("stall_hold", 1, 1, 3'd0, 1, 2'd0, 0, 2'd0, 0, 0, 1, 0, 2'd1, 0);
            check("stall_rt", 32'(rt_o), 32'd8);
            check("stall_cnt", 32'(bubble_cnt_o), 32'd3);
        end
        stall_i = 1'b0; tick();
        check_bubble("unstall_hz", 4);

        drive(I_LW8); tick();
        drive(I_ADD); instr_valid_i = 1'b0; #1;
        check("hz_invalid", 32'(hazard_stall_o), 32'd0);
        tick();
        check_bubble("invalid", 4);

        drive(I_LW8); tick();
        stall_i = 1'b1; rst_i = 1'b1; drive(I_ADD); tick();
        stall_i = 1'b0; rst_i = 1'b0;
        check_bubble("reset_mid_stall", 0);

        s_flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sat_cnt", 32'(s_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        s_flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
